led_fader_bank: RTL and testbench
=================================

// Module: led_fader_bank
// PURPOSE
//  Multi-channel LED fader. Each channel has its own brightness ramp with a
//  fade-in/fade-out state machine and an optional self-running "breathe" mode.
//  All channels share one PWM counter and one ramp-step prescaler.
//  Drives the board LED bus directly from top, with configurable output polarity.
// PARAMETERS
//  CHANNELS       6   number of independent LED channels
//  BITS           5   brightness width; MAX = 2^BITS-1 (BITS >= 2)
//  STEP_DIV_BITS  17  ramp step tick every 2^STEP_DIV_BITS clk cycles
//  ACTIVE_LOW     1   1: LED lit when output is 0; 0: LED lit when output is 1
// PORTS
//  clk     in   1               system clock
//  reset   in   1               synchronous, active-high reset
//  target  in   CHANNELS        per channel: 1 = fade toward MAX, 0 = fade toward 0
//  breathe in   CHANNELS        per channel: 1 = ramp 0..MAX..0 continuously; overrides target
//  led     out  CHANNELS        PWM output, registered, polarity set by ACTIVE_LOW
//  level   out  CHANNELS*BITS   current brightness; channel i at [i*BITS +: BITS]
//  busy    out  CHANNELS        1 while channel is in state UP or DOWN
// BEHAVIOUR
//  Reset (sync, active-high)
//   - pwm_cnt=0, presc=0; every channel goes to state=OFF, level=0, busy=0.
//   - led = inactive value ({CHANNELS{ACTIVE_LOW}}).
//   - Takes effect on the next clk edge, even mid-ramp. No fade-out on reset.
//  PWM
//   - pwm_cnt (BITS wide) increments every clk and wraps MAX -> 0.
//   - lit_i = (pwm_cnt < level_i). Registered: led_i = lit_i ^ ACTIVE_LOW.
//   - One clk of latency from pwm_cnt/level to led.
//   - level 0: never lit. level MAX: lit MAX of 2^BITS cycles.
//  Step tick
//   - presc (STEP_DIV_BITS wide) is free-running.
//   - tick=1 for exactly one clk when presc is all ones.
//   - State, level and input sampling change only on tick cycles.
//     Input changes between ticks are not latched.
//  Per-channel FSM (evaluated on tick; up = breathe_i | target_i)
//   OFF  : if up, then level<=1 and go to UP; otherwise hold.
//   UP   : if breathe_i=0 & target_i=0, then level<=level-1 and go to DOWN
//          (if the new level is 0, go to OFF);
//          otherwise level<=level+1 (if the new level is MAX, go to ON).
//   ON   : if breathe_i | ~target_i, then level<=MAX-1 and go to DOWN; otherwise hold.
//   DOWN : if target_i & ~breathe_i, then level<=level+1 and go to UP
//          (if the new level is MAX, go to ON);
//          otherwise level<=level-1 (if the new level is 0, go to OFF).
//   - Breathe always completes the full ramp to 0 or MAX before reversing.
//     Breathe period = 2*MAX ticks.
//   - level never wraps: it saturates at 0 (state OFF) and MAX (state ON).
//   - Channels are fully independent. All channels share pwm_cnt and tick.
//   - busy_i is combinational from state_i: it changes on the same edge as state.
// TESTING  (bench params: CHANNELS=2, BITS=3, STEP_DIV_BITS=2 -> MAX=7, tick every 4 clk)
//  1. Hold reset with target=2'b11 for 10 clk -> led=2'b11, level=0, busy=0 throughout.
//  2. Release reset, target[0]=1 -> level0 steps 1..7, one step per tick;
//     busy0=0 after 7th tick (28 clk); led[0] low 7 of 8 clk; ch1 level stays 0.
//  3. target[0]=1 until level0=4, then target[0]=0 -> next tick level0=3 (DOWN);
//     OFF at level 0 after 3 more ticks; busy0=0.
//  4. breathe[1]=1, target[1]=0 -> level1 = 0,1..7,6..1,0,1..; 14-tick period
//     (56 clk); ON/OFF never held longer than 1 tick.
//  5. Assert reset for 1 clk while level0=5 and ramping -> next clk: level0=0,
//     led[0]=1, busy0=0; stays OFF until the next tick with target set.
//  6. level0=3 steady -> led[0]=0 exactly for pwm_cnt 0,1,2 (one clk delayed);
//     1 otherwise. ACTIVE_LOW=0 build inverts led.

Source files
------------

// File: rtl/led_fader_bank.sv
// rtl/led_fader_bank.sv - multi-channel LED fader with shared PWM counter and ramp prescaler
module led_fader_bank #(
  parameter int CHANNELS      = 6,
  parameter int BITS          = 5,
  parameter int STEP_DIV_BITS = 17,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      target,
  input  logic [CHANNELS-1:0]      breathe,
  output logic [CHANNELS-1:0]      led,
  output logic [CHANNELS*BITS-1:0] level,
  output logic [CHANNELS-1:0]      busy
);

  typedef enum logic [1:0] {S_OFF, S_UP, S_ON, S_DOWN} state_t;

  localparam logic [BITS-1:0] ONE    = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [BITS-1:0] MAX    = {BITS{1'b1}};
  localparam logic [BITS-1:0] MAX_M1 = MAX - ONE;

  logic [BITS-1:0]          pwm_cnt_q;
  logic [STEP_DIV_BITS-1:0] presc_q;
  logic [CHANNELS-1:0]      led_q;
  logic [CHANNELS-1:0]      lit;
  logic                     tick;

  state_t          state_q [CHANNELS];
  state_t          state_d [CHANNELS];
  logic [BITS-1:0] level_q [CHANNELS];
  logic [BITS-1:0] level_d [CHANNELS];

  assign tick = &presc_q;
  assign led  = led_q;

  // Breathe overrides target: a breathing channel always ramps to the end before reversing.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      level_d[i] = level_q[i];
      if (tick) begin
        case (state_q[i])
          S_OFF: begin
            if (breathe[i] | target[i]) begin
              level_d[i] = ONE;
              state_d[i] = S_UP;
            end
          end
          S_UP: begin
            if (!breathe[i] && !target[i]) begin
              level_d[i] = level_q[i] - ONE;
              state_d[i] = (level_q[i] == ONE) ? S_OFF : S_DOWN;
            end else begin
              level_d[i] = level_q[i] + ONE;
              state_d[i] = (level_q[i] == MAX_M1) ? S_ON : S_UP;
            end
          end
          S_ON: begin
            if (breathe[i] | ~target[i]) begin
              level_d[i] = MAX_M1;
              state_d[i] = S_DOWN;
            end
          end
          S_DOWN: begin
            if (target[i] & ~breathe[i]) begin
              level_d[i] = level_q[i] + ONE;
              state_d[i] = (level_q[i] == MAX_M1) ? S_ON : S_UP;
            end else begin
              level_d[i] = level_q[i] - ONE;
              state_d[i] = (level_q[i] == ONE) ? S_OFF : S_DOWN;
            end
          end
          default: begin
            level_d[i] = '0;
            state_d[i] = S_OFF;
          end
        endcase
      end
    end
  end

  always_comb begin
    lit   = '0;
    busy  = '0;
    level = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lit[i]                 = (pwm_cnt_q < level_q[i]);
      busy[i]                = (state_q[i] == S_UP) || (state_q[i] == S_DOWN);
      level[i*BITS +: BITS]  = level_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      presc_q   <= '0;
      led_q     <= {CHANNELS{ACTIVE_LOW}};
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= S_OFF;
        level_q[i] <= '0;
      end
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      presc_q   <= presc_q + 1'b1;
      led_q     <= lit ^ {CHANNELS{ACTIVE_LOW}};
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        level_q[i] <= level_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_fader_bank.sv
// tb/tb_led_fader_bank.sv - directed bench for led_fader_bank (2 channels, 3-bit level, tick every 4 clk)
module tb_led_fader_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] target;
  logic [1:0] breathe;
  logic [1:0] led, led_hi;
  logic [5:0] level, level_hi;
  logic [1:0] busy, busy_hi;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_fader_bank #(.CHANNELS(2), .BITS(3), .STEP_DIV_BITS(2), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .target(target), .breathe(breathe),
    .led(led), .level(level), .busy(busy)
  );

  led_fader_bank #(.CHANNELS(2), .BITS(3), .STEP_DIV_BITS(2), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .target(target), .breathe(breathe),
    .led(led_hi), .level(level_hi), .busy(busy_hi)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int lows;
    int p;
    int e;

    reset   = 1'b1;
    target  = 2'b11;
    breathe = 2'b00;

    // 1: reset held
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("rst_led", led, 2'b11);
      chk("rst_led_hi", led_hi, 2'b00);
      chk("rst_level", level, 6'd0);
      chk("rst_busy", busy, 2'b00);
    end

    // 2: ramp channel 0 up, channel 1 idle
    reset  = 1'b0;
    target = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      step(4);
      chk("up_level0", level[2:0], k);
      chk("up_busy0", busy[0], (k < 7));
      chk("up_level1", level[5:3], 0);
    end
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (led[0] == 1'b0) lows++;
    end
    chk("max_duty", lows, 7);

    // 3: fade out, partial fade in, reverse at 4
    target = 2'b00;
    for (int k = 6; k >= 0; k--) begin
      step(4);
      chk("dn_level0", level[2:0], k);
      chk("dn_busy0", busy[0], (k > 0));
    end
    target = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      step(4);
      chk("up4_level0", level[2:0], k);
    end
    target = 2'b00;
    for (int k = 3; k >= 0; k--) begin
      step(4);
      chk("rev_level0", level[2:0], k);
      chk("rev_busy0", busy[0], (k > 0));
    end

    // 4: breathe on channel 1 for two periods
    breathe = 2'b10;
    for (int t = 1; t <= 28; t++) begin
      step(4);
      p = t % 14;
      e = (p <= 7) ? p : 14 - p;
      chk("br_level1", level[5:3], e);
      chk("br_busy1", busy[1], (e != 0) && (e != 7));
      chk("br_level0", level[2:0], 0);
    end
    breathe = 2'b00;

    // 5: reset mid-ramp at level 5
    target = 2'b01;
    for (int k = 1; k <= 5; k++) step(4);
    chk("pre_rst_level0", level[2:0], 5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midrst_level0", level[2:0], 0);
    chk("midrst_led0", led[0], 1'b1);
    chk("midrst_busy0", busy[0], 1'b0);
    step(3);
    chk("postrst_hold_level0", level[2:0], 0);
    chk("postrst_hold_busy0", busy[0], 1'b0);
    step(1);
    chk("postrst_tick_level0", level[2:0], 1);
    chk("postrst_tick_busy0", busy[0], 1'b1);

    // 6: reach level 3 aligned with pwm_cnt 0 (ON held one extra tick)
    for (int k = 2; k <= 7; k++) begin
      step(4);
      chk("r2_level0", level[2:0], k);
    end
    step(4);
    chk("on_hold_level0", level[2:0], 7);
    chk("on_hold_busy0", busy[0], 1'b0);
    target = 2'b00;
    for (int k = 6; k >= 3; k--) begin
      step(4);
      chk("d3_level0", level[2:0], k);
    end
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("pwm3_led0", led[0], (i == 3));
      chk("pwm3_led0_hi", led_hi[0], (i != 3));
      chk("pwm3_led1", led[1], 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
